result_collector: RTL and testbench

Downstream stage of the nibble-serial FSM datapath. It consumes the 4-bit result stream the FSM emits while output_valid is high and reassembles the full N-bit result word. It then re-serialises the word as OUT_W-bit bytes over a valid/ready handshake towards the pad/host side, and reports malformed streams with sticky error flags.

---
 rtl/result_collector_if.sv | 14 +
 rtl/result_collector.sv | 146 ++++++++++++++
 tb/tb_result_collector.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/result_collector_if.sv
// Nibble-in / byte-out handshake bundle shared by the result collector and its upstream/downstream.
interface result_collector_if #(
  parameter int N_width = 4,
  parameter int OUT_W   = 8
);
  logic               in_valid;
  logic [N_width-1:0] in_nibble;
  logic               out_ready;
  logic               out_valid;
  logic [OUT_W-1:0]   out_byte;

  modport master (output in_valid, in_nibble, out_ready, input out_valid, out_byte);
  modport slave  (input in_valid, in_nibble, out_ready, output out_valid, out_byte);
endinterface

// File: rtl/result_collector.sv
// Reassembles the FSM nibble stream into an N-bit word and drains it as OUT_W-bit bytes.
// Optional trailing XOR checksum byte: define RESULT_COLLECTOR_CHECKSUM_EN.
module result_collector #(
  parameter int N       = 64,
  parameter int N_width = 4,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  result_collector_if.slave  bus,
  output logic               word_done,
  output logic               short_err,
  output logic               overrun_err,
  output logic [1:0]         state_res
);
  localparam int NIB    = N / N_width;
  localparam int BYT    = N / OUT_W;
  localparam int NIB_CW = $clog2(NIB);
  localparam int DAT_IW = $clog2(BYT);
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  localparam int BI_W     = DAT_IW + 1;
  localparam int LAST_IDX = BYT;
`else
  localparam int BI_W     = DAT_IW;
  localparam int LAST_IDX = BYT - 1;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [NIB_CW-1:0] nib_cnt_q, nib_cnt_d;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [N-1:0]      word_q, word_d;
  logic              word_done_q, word_done_d;
  logic              short_err_q, short_err_d;
  logic              overrun_err_q, overrun_err_d;
  logic [DAT_IW-1:0] data_idx;

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  function automatic logic [OUT_W-1:0] word_xor(input logic [N-1:0] w);
    logic [OUT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < BYT; i++) acc = acc ^ w[i*OUT_W +: OUT_W];
    return acc;
  endfunction
`endif

  always_comb begin
    state_d       = state_q;
    nib_cnt_d     = nib_cnt_q;
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    word_done_d   = 1'b0;
    short_err_d   = short_err_q;
    overrun_err_d = overrun_err_q;
    if (clear) begin
      state_d       = IDLE;
      nib_cnt_d     = '0;
      byte_idx_d    = '0;
      word_d        = '0;
      short_err_d   = 1'b0;
      overrun_err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            word_d              = '0;
            word_d[N_width-1:0] = bus.in_nibble;
            nib_cnt_d           = NIB_CW'(1);
            state_d             = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.in_valid) begin
            word_d[nib_cnt_q*N_width +: N_width] = bus.in_nibble;
            nib_cnt_d = nib_cnt_q + NIB_CW'(1);
            if (nib_cnt_q == NIB_CW'(NIB - 1)) begin
              state_d    = DRAIN;
              byte_idx_d = '0;
            end
          end else begin
            // Gap in the stream: the partial word is useless, so drop it and flag.
            short_err_d = 1'b1;
            nib_cnt_d   = '0;
            state_d     = IDLE;
          end
        end
        DRAIN: begin
          if (bus.in_valid) overrun_err_d = 1'b1;
          if (bus.out_ready) begin
            if (byte_idx_q == BI_W'(LAST_IDX)) begin
              byte_idx_d  = '0;
              nib_cnt_d   = '0;
              word_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              byte_idx_d = byte_idx_q + BI_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      nib_cnt_q     <= '0;
      byte_idx_q    <= '0;
      word_q        <= '0;
      word_done_q   <= 1'b0;
      short_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      nib_cnt_q     <= nib_cnt_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      word_done_q   <= word_done_d;
      short_err_q   <= short_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign data_idx = byte_idx_q[DAT_IW-1:0];

  always_comb begin
    bus.out_valid = (state_q == DRAIN);
    bus.out_byte  = '0;
    if (state_q == DRAIN) begin
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
      if (byte_idx_q == BI_W'(BYT)) bus.out_byte = word_xor(word_q);
      else                          bus.out_byte = word_q[data_idx*OUT_W +: OUT_W];
`else
      bus.out_byte = word_q[data_idx*OUT_W +: OUT_W];
`endif
    end
  end

  assign word_done   = word_done_q;
  assign short_err   = short_err_q;
  assign overrun_err = overrun_err_q;
  assign state_res   = state_q;
endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: directed words, queued expected bytes, negedge monitor.
module tb_result_collector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic word_done, short_err, overrun_err;
  logic [1:0] state_res;

  result_collector_if #(.N_width(4), .OUT_W(8)) bus ();

  result_collector #(.N(64), .N_width(4), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus),
    .word_done(word_done), .short_err(short_err),
    .overrun_err(overrun_err), .state_res(state_res)
  );

  always #5 clk = ~clk;

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  localparam int EXP_BYTES = 9;
`else
  localparam int EXP_BYTES = 8;
`endif

  logic [7:0] sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int wd_cnt   = 0;
  logic wd_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pops one expected byte.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", bus.out_byte, $time);
        end else begin
          check("out_byte", bus.out_byte, sb_q.pop_front());
        end
      end
      if (word_done) begin
        wd_cnt++;
        check("word_done_single_cycle", wd_prev, 1'b0);
      end
      wd_prev = word_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_nibble = w[i*4 +: 4];
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.in_nibble = 4'h0;
  endtask

  task automatic push_bytes(input logic [63:0] w);
    for (int i = 0; i < 8; i++) sb_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((sb_q.size() != 0 || state_res != 2'd0) && c < 200) begin
      tick();
      c++;
    end
    check({name, "_drain_timeout"}, (c < 200), 1'b1);
    tick();
    tick();
  endtask

  initial begin
    int hs0, wd0;
    bus.in_valid  = 1'b0;
    bus.in_nibble = 4'h0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_state", state_res, 2'd0);
    check("rst_word_done", word_done, 1'b0);
    #21 rst = 1'b1;
    tick();
    check("post_rst_state", state_res, 2'd0);

    // Test 2: nibbles 0..F, out_ready held high.
    wd0 = wd_cnt;
    hs0 = hs_cnt;
    sb_q.push_back(8'h10); sb_q.push_back(8'h32); sb_q.push_back(8'h54); sb_q.push_back(8'h76);
    sb_q.push_back(8'h98); sb_q.push_back(8'hBA); sb_q.push_back(8'hDC); sb_q.push_back(8'hFE);
    bus.out_ready = 1'b1;
    send(64'hFEDC_BA98_7654_3210, 15);
    check("t2_collect_state", state_res, 2'd1);
    check("t2_no_valid_while_collecting", bus.out_valid, 1'b0);
    bus.in_valid = 1'b1; bus.in_nibble = 4'hF;
    tick();
    bus.in_valid = 1'b0;
    check("t2_first_valid_latency", bus.out_valid, 1'b1);
    check("t2_drain_state", state_res, 2'd2);
    wait_idle("t2");
    check("t2_handshakes", hs_cnt - hs0, 8);
    check("t2_word_done_pulses", wd_cnt - wd0, 1);

    // Test 3: same word, out_ready pattern 1,0,0 repeating.
    hs0 = hs_cnt;
    bus.out_ready = 1'b0;
    push_bytes(64'hFEDC_BA98_7654_3210);
    send(64'hFEDC_BA98_7654_3210, 16);
    for (int k = 0; k < 60 && state_res == 2'd2; k++) begin
      bus.out_ready = (k % 3 == 0);
      if (k == 1 || k == 2) begin
        check("t3_stall_valid", bus.out_valid, 1'b1);
        check("t3_stall_byte", bus.out_byte, 8'h32);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    wait_idle("t3");
    check("t3_handshakes", hs_cnt - hs0, 8);

    // Test 4: stream breaks after 5 nibbles.
    hs0 = hs_cnt;
    send(64'h0000_0000_000A_BCDE, 5);
    tick();
    check("t4_short_err", short_err, 1'b1);
    check("t4_state_idle", state_res, 2'd0);
    check("t4_no_valid", bus.out_valid, 1'b0);
    check("t4_no_bytes", hs_cnt - hs0, 0);
    wd0 = wd_cnt;
    push_bytes(64'h0123_4567_89AB_CDEF);
    bus.out_ready = 1'b1;
    send(64'h0123_4567_89AB_CDEF, 16);
    wait_idle("t4");
    check("t4_word_done", wd_cnt - wd0, 1);
    check("t4_short_err_sticky", short_err, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_clear_short_err", short_err, 1'b0);

    // Test 5: in_valid during DRAIN.
    bus.out_ready = 1'b0;
    push_bytes(64'h1122_3344_5566_7788);
    send(64'h1122_3344_5566_7788, 16);
    check("t5_no_overrun_yet", overrun_err, 1'b0);
    bus.in_valid = 1'b1; bus.in_nibble = 4'hF;
    tick();
    bus.in_valid = 1'b0;
    check("t5_overrun_err", overrun_err, 1'b1);
    check("t5_still_drain", state_res, 2'd2);
    check("t5_byte0_intact", bus.out_byte, 8'h88);
    bus.out_ready = 1'b1;
    wait_idle("t5");

    // Test 1: asynchronous reset in the middle of DRAIN.
    bus.out_ready = 1'b0;
    send(64'hAAAA_5555_AAAA_5555, 16);
    tick();
    check("t1_in_drain", bus.out_valid, 1'b1);
    check("t1_overrun_before_rst", overrun_err, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t1_rst_out_valid", bus.out_valid, 1'b0);
    check("t1_rst_out_byte", bus.out_byte, 8'h00);
    check("t1_rst_state", state_res, 2'd0);
    check("t1_rst_overrun", overrun_err, 1'b0);
    check("t1_rst_short", short_err, 1'b0);
    #10 rst = 1'b1;
    tick();
    check("t1_post_state", state_res, 2'd0);
    check("t1_post_valid", bus.out_valid, 1'b0);

    // Test 6: single non-zero nibble (checksum byte appended when enabled).
    hs0 = hs_cnt;
    wd0 = wd_cnt;
    sb_q.push_back(8'h05);
    for (int i = 0; i < 7; i++) sb_q.push_back(8'h00);
    if (EXP_BYTES == 9) sb_q.push_back(8'h05);
    bus.out_ready = 1'b1;
    send(64'h0000_0000_0000_0005, 16);
    wait_idle("t6");
    check("t6_handshakes", hs_cnt - hs0, EXP_BYTES);
    check("t6_word_done", wd_cnt - wd0, 1);

    // clear wins over in_valid mid-COLLECT.
    send(64'h0000_0000_0000_0FFF, 3);
    bus.in_valid = 1'b1; bus.in_nibble = 4'h7;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_state_idle", state_res, 2'd0);
    check("clear_short_err", short_err, 1'b0);
    tick();
    check("clear_no_valid", bus.out_valid, 1'b0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
